cnt_bank: RTL and testbench
===========================

CNT_BANK -- requirements
Module: cnt_bank

Interface
- REQ-001 SHALL have parameter Width, default 12: bits per channel counter.
- REQ-002 SHALL have parameter Chans, default 4: number of independent channels.
- REQ-003 SHALL have parameter Mode, default 0: 0 = wrap, 1 = saturate (applies to all channels).
- REQ-004 SHALL have port CLK, input, 1: single clock; all state on rising edge.
- REQ-005 SHALL have port RST_N, input, 1: reset is asynchronous and active-low.
- REQ-006 SHALL have port SRST, input, 1: synchronous clear of all channels.
- REQ-007 SHALL have port CE, input, Chans: per-channel count enable.
- REQ-008 SHALL have port UP, input, Chans: per-channel direction (1 = up, 0 = down).
- REQ-009 SHALL have port LD, input, Chans: per-channel load strobe.
- REQ-010 SHALL have port DIN, input, Width: shared load value.
- REQ-011 SHALL have port LIMIT, input, Width: shared terminal value; count range 0..LIMIT.
- REQ-012 SHALL have port OVF_CLR, input, Chans: per-channel sticky-flag clear.
- REQ-013 SHALL have port Q, output, Chans*Width: channel n occupies bits [n*Width +: Width].
- REQ-014 SHALL have port TC, output, Chans: registered one-cycle boundary pulse.
- REQ-015 SHALL have port OVF, output, Chans: sticky boundary flag.

Function
- REQ-016 Per-channel priority SHALL be SRST > LD > CE > hold.
- REQ-017 LD SHALL load min(DIN, LIMIT); Q reflects it the next cycle.
- REQ-018 CE up with count < LIMIT SHALL increment by 1; CE down with count > 0 SHALL decrement by 1.
- REQ-019 Boundary event: CE up with count >= LIMIT, or CE down with count == 0.
- REQ-020 On a boundary event, Mode 0 SHALL set count to 0 (up) or LIMIT (down); Mode 1 SHALL set count to LIMIT (up) or 0 (down).
- REQ-021 A boundary event SHALL assert TC for exactly the following cycle and set OVF.
- REQ-022 TC SHALL be 0 in any cycle not preceded by a boundary event, including after LD or SRST.
- REQ-023 OVF SHALL stay set until OVF_CLR or SRST; when set and OVF_CLR arrive in the same cycle, set wins.
- REQ-024 If LIMIT changes below a live count, the count SHALL be held (not clamped) until the next CE or LD; the next CE up is a boundary event.
- REQ-025 LIMIT = 0: every CE SHALL be a boundary event, Q stays 0, and TC pulses on each CE.
- REQ-026 Channels SHALL be fully independent; latency from any input to Q/TC/OVF is 1 cycle.

Reset
- REQ-027 RST_N low SHALL clear Q, TC and OVF to 0 immediately, regardless of CLK.
- REQ-028 SRST SHALL clear Q, TC and OVF to 0 on the next edge, overriding LD, CE and OVF_CLR.
- REQ-029 Release of RST_N mid-sequence SHALL resume from all-zero state with no spurious TC.

Configuration
- REQ-030 With CNT_BANK_TMR_EN defined, each channel's count, TC and OVF registers SHALL be triplicated and marked preserved; a bitwise majority vote SHALL feed both the next-state logic and the outputs, so a single upset corrects within one cycle.
- REQ-031 Without CNT_BANK_TMR_EN, the block SHALL use single registers with identical cycle behaviour.

Structure
- REQ-032 Shared package SHALL hold the MODE_WRAP = 0 and MODE_SAT = 1 constants and the default Width and Chans values.
- REQ-033 One sub-module, cnt_bank_chan (one channel, including its TMR option), SHALL be instantiated Chans times by a generate loop.
- REQ-034 TMR voting SHALL reuse the existing vote module.

Verification
- REQ-035 Width=4, LIMIT=9, Mode 0, CE up for 12 cycles from 0 -> Q 1..9, 0, 1, 2; TC high the cycle after the 9->0 step; OVF = 1.
- REQ-036 Mode 1, LIMIT=5, down from 2 for 4 CEs -> Q 1, 0, 0, 0; TC pulses twice; OVF = 1.
- REQ-037 LD with DIN=14, LIMIT=9 -> Q = 9 next cycle; LD and CE together -> load wins.
- REQ-038 SRST and LD together, then RST_N asserted mid-count on channel 2 -> all Q/TC/OVF = 0, no TC after release.
- REQ-039 OVF_CLR in the same cycle as a boundary event -> OVF stays 1; OVF_CLR alone next cycle -> OVF = 0.
- REQ-040 CNT_BANK_TMR_EN defined, force one replica of channel 0 to 0xF while Q = 3 -> Q stays 3; replica is corrected by the next edge.

Source files
------------

// File: rtl/cnt_bank_pkg.sv
// Shared constants for the cnt_bank counter bank: overflow modes and default sizing.
package cnt_bank_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SAT      = 1;
    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_CHANS = 4;

endpackage

// File: rtl/cnt_bank_chan.sv
// One counter channel: load/count/hold with a 0..limit range, boundary pulse
// and sticky boundary flag. With CNT_BANK_TMR_EN defined the state registers
// are triplicated and voted; the voted value feeds both next-state and outputs.
module cnt_bank_chan
    import cnt_bank_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int Mode  = MODE_WRAP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             srst_i,
    input  logic             ce_i,
    input  logic             up_i,
    input  logic             ld_i,
    input  logic [Width-1:0] din_i,
    input  logic [Width-1:0] limit_i,
    input  logic             ovf_clr_i,
    output logic [Width-1:0] q_o,
    output logic             tc_o,
    output logic             ovf_o
);

    localparam logic [Width-1:0] ONE = Width'(1);

    logic [Width-1:0] cnt_v, cnt_d;
    logic             tc_v, tc_d;
    logic             ovf_v, ovf_d;

    // Next state: srst over load over count over hold; a set of the sticky flag beats its clear.
    always_comb begin
        cnt_d = cnt_v;
        tc_d  = 1'b0;
        ovf_d = ovf_v & ~ovf_clr_i;
        if (srst_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (ld_i) begin
            cnt_d = (din_i > limit_i) ? limit_i : din_i;
        end else if (ce_i) begin
            if (up_i) begin
                // A count left above a lowered limit is also a boundary here.
                if (cnt_v >= limit_i) begin
                    cnt_d = (Mode == MODE_SAT) ? limit_i : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_v + ONE;
                end
            end else begin
                if (cnt_v == '0) begin
                    cnt_d = (Mode == MODE_SAT) ? '0 : limit_i;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_v - ONE;
                end
            end
        end
    end

`ifdef CNT_BANK_TMR_EN
    (* keep = "true" *) logic [Width-1:0] cnt_q [3];
    (* keep = "true" *) logic [2:0]       tc_q;
    (* keep = "true" *) logic [2:0]       ovf_q;

    // Three replicas all load the same voted next state, so one upset heals in a cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r] <= '0;
                tc_q[r]  <= 1'b0;
                ovf_q[r] <= 1'b0;
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r] <= cnt_d;
                tc_q[r]  <= tc_d;
                ovf_q[r] <= ovf_d;
            end
        end
    end

    vote #(.W(Width)) u_vote_cnt (
        .a_i(cnt_q[0]), .b_i(cnt_q[1]), .c_i(cnt_q[2]), .y_o(cnt_v)
    );
    vote #(.W(1)) u_vote_tc (
        .a_i(tc_q[0]), .b_i(tc_q[1]), .c_i(tc_q[2]), .y_o(tc_v)
    );
    vote #(.W(1)) u_vote_ovf (
        .a_i(ovf_q[0]), .b_i(ovf_q[1]), .c_i(ovf_q[2]), .y_o(ovf_v)
    );
`else
    logic [Width-1:0] cnt_q;
    logic             tc_q;
    logic             ovf_q;

    // Single-copy state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_v = cnt_q;
    assign tc_v  = tc_q;
    assign ovf_v = ovf_q;
`endif

    assign q_o   = cnt_v;
    assign tc_o  = tc_v;
    assign ovf_o = ovf_v;

endmodule

// File: rtl/cnt_bank_vote.sv
// Bitwise 2-of-3 majority voter used by the triplicated counter channel.
// Only compiled when CNT_BANK_TMR_EN is defined.
`ifdef CNT_BANK_TMR_EN
module vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] y_o
);

    // Any two agreeing replicas decide each bit.
    assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule
`endif

// File: rtl/cnt_bank.sv
// Bank of Chans independent up/down counters sharing load value and limit.
// Optional triple-modular redundancy per channel via CNT_BANK_TMR_EN.
module cnt_bank
    import cnt_bank_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int Chans = DEFAULT_CHANS,
    parameter int Mode  = MODE_WRAP
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   SRST,
    input  logic [Chans-1:0]       CE,
    input  logic [Chans-1:0]       UP,
    input  logic [Chans-1:0]       LD,
    input  logic [Width-1:0]       DIN,
    input  logic [Width-1:0]       LIMIT,
    input  logic [Chans-1:0]       OVF_CLR,
    output logic [Chans*Width-1:0] Q,
    output logic [Chans-1:0]       TC,
    output logic [Chans-1:0]       OVF
);

    for (genvar n = 0; n < Chans; n++) begin : g_chan
        cnt_bank_chan #(
            .Width(Width),
            .Mode (Mode)
        ) u_chan (
            .clk_i    (CLK),
            .rst_ni   (RST_N),
            .srst_i   (SRST),
            .ce_i     (CE[n]),
            .up_i     (UP[n]),
            .ld_i     (LD[n]),
            .din_i    (DIN),
            .limit_i  (LIMIT),
            .ovf_clr_i(OVF_CLR[n]),
            .q_o      (Q[n*Width +: Width]),
            .tc_o     (TC[n]),
            .ovf_o    (OVF[n])
        );
    end

endmodule

// File: tb/tb_cnt_bank.sv
// Bench for cnt_bank: table of per-cycle vectors with hand-derived expectations,
// scoreboard queue for 1-cycle latency, plus hand sequences for async reset and TMR.
module tb_cnt_bank;

    localparam int W = 4;
    localparam int C = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b1;
    logic         SRST = 1'b0;
    logic [C-1:0] CE = '0, UP = '0, LD = '0, OVF_CLR = '0;
    logic [W-1:0] DIN = '0, LIMIT = '0;
    logic [C*W-1:0] Q0, Q1;
    logic [C-1:0]   TC0, TC1, OVF0, OVF1;

    cnt_bank #(.Width(W), .Chans(C), .Mode(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .SRST(SRST), .CE(CE), .UP(UP), .LD(LD),
        .DIN(DIN), .LIMIT(LIMIT), .OVF_CLR(OVF_CLR), .Q(Q0), .TC(TC0), .OVF(OVF0)
    );

    cnt_bank #(.Width(W), .Chans(C), .Mode(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .SRST(SRST), .CE(CE), .UP(UP), .LD(LD),
        .DIN(DIN), .LIMIT(LIMIT), .OVF_CLR(OVF_CLR), .Q(Q1), .TC(TC1), .OVF(OVF1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         m;
        int         ch;
        bit         srst;
        logic [3:0] ce, up, ld, clr;
        logic [3:0] din, lim;
        logic [3:0] eq;
        bit         etc, eovf;
    } vec_t;

    typedef struct {
        bit         m;
        int         ch;
        int         id;
        logic [3:0] q;
        bit         tc, ovf;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    function automatic vec_t mk(bit m, int ch, bit srst, logic [3:0] ce, logic [3:0] up,
                                logic [3:0] ld, logic [3:0] din, logic [3:0] lim,
                                logic [3:0] clr, logic [3:0] eq, bit etc, bit eovf);
        vec_t v;
        v.m = m; v.ch = ch; v.srst = srst; v.ce = ce; v.up = up; v.ld = ld;
        v.din = din; v.lim = lim; v.clr = clr; v.eq = eq; v.etc = etc; v.eovf = eovf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic run(input vec_t v, input int id);
        exp_t e;
        logic [3:0] aq;
        logic       atc, aovf;
        @(negedge CLK);
        SRST = v.srst; CE = v.ce; UP = v.up; LD = v.ld;
        DIN = v.din; LIMIT = v.lim; OVF_CLR = v.clr;
        e.m = v.m; e.ch = v.ch; e.id = id; e.q = v.eq; e.tc = v.etc; e.ovf = v.eovf;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        aq   = e.m ? Q1[e.ch*W +: W] : Q0[e.ch*W +: W];
        atc  = e.m ? TC1[e.ch]  : TC0[e.ch];
        aovf = e.m ? OVF1[e.ch] : OVF0[e.ch];
        check($sformatf("v%0d_q", e.id),   16'(aq),   16'(e.q));
        check($sformatf("v%0d_tc", e.id),  16'(atc),  16'(e.tc));
        check($sformatf("v%0d_ovf", e.id), 16'(aovf), 16'(e.ovf));
    endtask

    initial begin
        // Async reset at power-up, checked before any clock edge.
        #1 RST_N = 1'b0;
        #2;
        check("rst_q",   Q0,        16'h0);
        check("rst_tc",  16'(TC0),  16'h0);
        check("rst_ovf", 16'(OVF0), 16'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 9, 0, 0, 0, 0));
        // Mode 0 wrap up, LIMIT 9.
        for (int i = 1; i <= 9; i++) vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9, 0, 4'(i), 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9, 0, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9, 0, 2, 0, 1));
        // Independence: ch1 idle while ch0 counts, then ch0 holds.
        vt.push_back(mk(0, 1, 0, 1, 1, 0, 0, 9, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 0, 3, 0, 1));
        // Sticky flag clear and set-beats-clear.
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 1, 3, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 9, 9, 0, 9, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0));
        // Load clamps to LIMIT; load beats count.
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 14, 9, 0, 9, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 1, 1, 5, 9, 0, 5, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 9, 0, 3, 0, 0));
        // LIMIT lowered below live count: hold, count down normally, up is boundary.
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 7, 9, 0, 7, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 7, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 0, 6, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 7, 2, 0, 2, 0, 1));
        // LIMIT 0: every CE is a boundary.
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Mode 0 down wrap to LIMIT, then SRST over LD/CE right after a boundary.
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9, 0, 9, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9, 0, 8, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9, 0, 9, 1, 1));
        vt.push_back(mk(0, 0, 1, 4'hF, 4'hF, 4'hF, 5, 9, 0, 0, 0, 0));
        vt.push_back(mk(0, 3, 1, 4'hF, 0, 4'hF, 5, 9, 0, 0, 0, 0));
        // Mode 1 saturate, LIMIT 5.
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 2, 5, 0, 2, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 5, 5, 0, 5, 0, 1));
        vt.push_back(mk(1, 0, 0, 1, 1, 0, 0, 5, 0, 5, 1, 1));
        // Channel 2 runs to a boundary at LIMIT 2 ahead of the async reset.
        vt.push_back(mk(0, 2, 0, 4'b0100, 4'b0100, 0, 0, 2, 0, 1, 0, 0));
        vt.push_back(mk(0, 2, 0, 4'b0100, 4'b0100, 0, 0, 2, 0, 2, 0, 0));
        vt.push_back(mk(0, 2, 0, 4'b0100, 4'b0100, 0, 0, 2, 0, 0, 1, 1));

        for (int i = 0; i < vt.size(); i++) run(vt[i], i);

        // Async reset mid-count, away from any edge, with CE still asserted.
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_q",   Q0,        16'h0);
        check("arst_tc",  16'(TC0),  16'h0);
        check("arst_ovf", 16'(OVF0), 16'h0);
        @(posedge CLK);
        #1 check("arst_hold_q", Q0, 16'h0);
        @(negedge CLK);
        CE = '0;
        RST_N = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("rel%0d_tc", k), 16'(TC0), 16'h0);
            check($sformatf("rel%0d_q", k),  Q0,       16'h0);
        end
        run(mk(0, 2, 0, 4'b0100, 4'b0100, 0, 0, 9, 0, 1, 0, 0), 100);

`ifdef CNT_BANK_TMR_EN
        // Upset one replica of channel 0; the vote masks it and the next edge repairs it.
        run(mk(0, 0, 0, 0, 0, 1, 3, 9, 0, 3, 0, 0), 200);
        @(negedge CLK);
        LD = '0;
        dut0.g_chan[0].u_chan.cnt_q[1] = 4'hF;
        #1 check("tmr_mask_q", 16'(Q0[3:0]), 16'h3);
        @(posedge CLK);
        #1;
        check("tmr_fix_rep", 16'(dut0.g_chan[0].u_chan.cnt_q[1]), 16'h3);
        check("tmr_fix_q",   16'(Q0[3:0]), 16'h3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
